// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared datapath constants and types for the accumulator CPU.
//                DATA_W   - register/word width
//                IDX_W    - register index width
//                NUM_REGS - register count (always 2**IDX_W)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int IDX_W    = 3;
    localparam int NUM_REGS = 1 << IDX_W;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : reg_ptr
//  Description : Load-enable pointer register with synchronous active-high
//                reset. Holds a register index for the register file.
//  Ports       : clk_i  - clock (rising edge)
//                rst_i  - synchronous reset, clears the pointer to 0
//                load_i - load d_i on the next rising edge
//                d_i    - index to load
//                q_o    - current pointer value
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_ptr
    import cpu_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign q_o = ptr_q;

endmodule : reg_ptr
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : General-purpose register file with one shared index port.
//                rt_index drives the combinational rt read and is the load
//                value for the source and destination pointers. Writes go to
//                the destination pointer as it stood before the write edge.
//  Ports       : CLK         - clock (rising edge)
//                RESET       - synchronous active-high reset
//                REGWRITE    - write write_value into regs[dest_ptr]
//                SETSRC      - load src_ptr from rt_index
//                SETDEST     - load dest_ptr from rt_index
//                rt_index    - index for rt read and pointer loads
//                write_value - data to write
//                rs          - regs[src_ptr]  (combinational)
//                rt          - regs[rt_index] (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int IDX_W    = cpu_pkg::IDX_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REGWRITE,
    input  logic              SETSRC,
    input  logic              SETDEST,
    input  logic [IDX_W-1:0]  rt_index,
    input  logic [DATA_W-1:0] write_value,
    output logic [DATA_W-1:0] rs,
    output logic [DATA_W-1:0] rt
);

    logic [IDX_W-1:0]  src_ptr;
    logic [IDX_W-1:0]  dest_ptr;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // ------------------------------------------------------------------
    // Pointer registers
    // ------------------------------------------------------------------
    reg_ptr #(
        .W (IDX_W)
    ) u_src_ptr (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .load_i (SETSRC),
        .d_i    (rt_index),
        .q_o    (src_ptr)
    );

    reg_ptr #(
        .W (IDX_W)
    ) u_dest_ptr (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .load_i (SETDEST),
        .d_i    (rt_index),
        .q_o    (dest_ptr)
    );

    // ------------------------------------------------------------------
    // Storage. dest_ptr here is the registered value, so a SETDEST in the
    // same cycle as REGWRITE only redirects later writes.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (REGWRITE) begin
            regs_d[dest_ptr] = write_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read paths read stored state only; no write-through bypass.
    assign rs = regs_q[src_ptr];
    assign rt = regs_q[rt_index];

    // ------------------------------------------------------------------
    // Assertions (state before the first reset is undefined, so checks
    // are held off until a reset has been seen).
    // ------------------------------------------------------------------
    logic rst_seen_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rst_seen_q <= 1'b1;
        end
    end

    a_no_x_reads : assert property (@(posedge CLK) disable iff (RESET || (rst_seen_q !== 1'b1))
        !$isunknown(rs) && !$isunknown(rt));

    a_dest_stable_on_write : assert property (@(posedge CLK) disable iff (RESET || (rst_seen_q !== 1'b1))
        (REGWRITE && !SETDEST) |=> $stable(dest_ptr));

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed self-checking bench for reg_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic       CLK;
    logic       RESET;
    logic       REGWRITE;
    logic       SETSRC;
    logic       SETDEST;
    logic [2:0] rt_index;
    logic [7:0] write_value;
    logic [7:0] rs;
    logic [7:0] rt;

    int errors;
    int checks;

    reg_file dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REGWRITE    (REGWRITE),
        .SETSRC      (SETSRC),
        .SETDEST     (SETDEST),
        .rt_index    (rt_index),
        .write_value (write_value),
        .rs          (rs),
        .rt          (rt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET    = 1'b0;
        REGWRITE = 1'b0;
        SETSRC   = 1'b0;
        SETDEST  = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        checks++;
        if (rs !== 8'h00) begin
            errors++;
            $display("FAIL reset_rs: got %h expected %h", rs, 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            rt_index = i[2:0];
            #1;
            checks++;
            if (rt !== 8'h00) begin
                errors++;
                $display("FAIL reset_rt[%0d]: got %h expected %h", i, rt, 8'h00);
            end
        end
    endtask

    task automatic test_ptr_write();
        SETSRC = 1'b1; rt_index = 3'd6;
        tick();
        idle();
        SETDEST = 1'b1; rt_index = 3'd5;
        tick();
        idle();
        REGWRITE = 1'b1; write_value = 8'd26; rt_index = 3'd5;
        #1;
        // Before the write edge the old contents must still be visible.
        checks++;
        if (rt !== 8'h00) begin
            errors++;
            $display("FAIL no_bypass_rt5: got %h expected %h", rt, 8'h00);
        end
        tick();
        idle();
        rt_index = 3'd5;
        #1;
        checks++;
        if (rt !== 8'd26) begin
            errors++;
            $display("FAIL ptr_write_rt5: got %h expected %h", rt, 8'd26);
        end
        checks++;
        if (rs !== 8'h00) begin
            errors++;
            $display("FAIL ptr_write_rs: got %h expected %h", rs, 8'h00);
        end
        rt_index = 3'd6;
        #1;
        checks++;
        if (rt !== 8'h00) begin
            errors++;
            $display("FAIL ptr_write_rt6: got %h expected %h", rt, 8'h00);
        end
    endtask

    task automatic test_src_readback();
        SETSRC = 1'b1; rt_index = 3'd0;
        tick();
        idle();
        SETDEST = 1'b1; rt_index = 3'd6;
        tick();
        idle();
        REGWRITE = 1'b1; write_value = 8'hA5;
        tick();
        idle();
        checks++;
        if (rs !== 8'h00) begin
            errors++;
            $display("FAIL src_before_set: got %h expected %h", rs, 8'h00);
        end
        SETSRC = 1'b1; rt_index = 3'd6;
        tick();
        idle();
        checks++;
        if (rs !== 8'hA5) begin
            errors++;
            $display("FAIL src_readback_rs: got %h expected %h", rs, 8'hA5);
        end
        rt_index = 3'd6;
        #1;
        checks++;
        if (rt !== 8'hA5) begin
            errors++;
            $display("FAIL src_readback_rt6: got %h expected %h", rt, 8'hA5);
        end
    endtask

    task automatic test_same_cycle();
        SETDEST = 1'b1; rt_index = 3'd2;
        tick();
        idle();
        SETDEST = 1'b1; REGWRITE = 1'b1; rt_index = 3'd7; write_value = 8'h3C;
        tick();
        idle();
        rt_index = 3'd2;
        #1;
        checks++;
        if (rt !== 8'h3C) begin
            errors++;
            $display("FAIL same_cycle_rt2: got %h expected %h", rt, 8'h3C);
        end
        rt_index = 3'd7;
        #1;
        checks++;
        if (rt !== 8'h00) begin
            errors++;
            $display("FAIL same_cycle_rt7: got %h expected %h", rt, 8'h00);
        end
        REGWRITE = 1'b1; write_value = 8'h11;
        tick();
        idle();
        rt_index = 3'd7;
        #1;
        checks++;
        if (rt !== 8'h11) begin
            errors++;
            $display("FAIL followup_rt7: got %h expected %h", rt, 8'h11);
        end
        rt_index = 3'd2;
        #1;
        checks++;
        if (rt !== 8'h3C) begin
            errors++;
            $display("FAIL followup_rt2: got %h expected %h", rt, 8'h3C);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            SETDEST = 1'b1; rt_index = i[2:0];
            tick();
            idle();
            exp = 8'(i * 17);
            REGWRITE = 1'b1; write_value = exp;
            tick();
            idle();
        end
        for (int i = 0; i < 8; i++) begin
            exp = 8'(i * 17);
            rt_index = i[2:0];
            #1;
            checks++;
            if (rt !== exp) begin
                errors++;
                $display("FAIL sweep_rt[%0d]: got %h expected %h", i, rt, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        SETDEST = 1'b1; rt_index = 3'd4;
        tick();
        idle();
        RESET = 1'b1; REGWRITE = 1'b1; write_value = 8'h55;
        tick();
        idle();
        rt_index = 3'd4;
        #1;
        checks++;
        if (rt !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_rt4: got %h expected %h", rt, 8'h00);
        end
        checks++;
        if (rs !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_rs: got %h expected %h", rs, 8'h00);
        end
        REGWRITE = 1'b1; write_value = 8'h77;
        tick();
        idle();
        rt_index = 3'd0;
        #1;
        checks++;
        if (rt !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_rt0: got %h expected %h", rt, 8'h77);
        end
        // src_ptr was also cleared, so rs follows reg 0.
        checks++;
        if (rs !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_rs: got %h expected %h", rs, 8'h77);
        end
        rt_index = 3'd4;
        #1;
        checks++;
        if (rt !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_rt4: got %h expected %h", rt, 8'h00);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        RESET       = 1'b0;
        REGWRITE    = 1'b0;
        SETSRC      = 1'b0;
        SETDEST     = 1'b0;
        rt_index    = 3'd0;
        write_value = 8'h00;

        test_reset();
        test_ptr_write();
        test_src_readback();
        test_same_cycle();
        test_sweep();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
